tug_score_tracker: RTL
======================

// Module: tug_score_tracker
// PURPOSE
//  Parametrised tug-of-war scoreboard: counts left/right point events, drives a
//  symmetric thermometer LED bar, and flags game over with the winning side.
//  Adds a rope mode, in which points pull a net position, and a restartable
//  PLAY/OVER FSM. Sits between round-win logic and the LED output driver.
// PARAMETERS
//  WIN_PTS  3  points needed to win (>=1); LED bar width = 2*WIN_PTS+1
//  CW       $clog2(WIN_PTS+1)  score counter width (localparam, derived)
// PORTS
//  clk       in   1            system clock, rising edge
//  rst       in   1            synchronous, active-high reset
//  point_l   in   1            left round-won level (already synchronous to clk)
//  point_r   in   1            right round-won level (already synchronous to clk)
//  rope_mode in   1            0 = independent race, 1 = net rope position
//  new_game  in   1            one-cycle pulse: clear scores, enter PLAY
//  score_l   out  CW           left score / left rope offset
//  score_r   out  CW           right score / right rope offset
//  game_led  out  2*WIN_PTS+1  thermometer bar, bit WIN_PTS = centre
//  over      out  1            1 while FSM is in OVER
//  winright  out  1            1 = right won; valid only while over=1
// BEHAVIOUR
//  - Reset: rst=1 at a clock edge clears score_l, score_r, over, winright and
//    both edge-detect registers, and sets state=PLAY. game_led=centre bit only.
//    Reset overrides every other input, including mid-game.
//  - Edge detect: ev_l = point_l & ~point_l_q. ev_r is formed the same way.
//    Each prev register is updated every cycle in every state.
//    A held level counts exactly once.
//  - Simultaneous ev_l & ev_r in the same cycle: both are discarded and no
//    score changes.
//  - PLAY, race mode (rope_mode=0): ev_l -> score_l+1; ev_r -> score_r+1.
//  - PLAY, rope mode (rope_mode=1): ev_l -> if score_r>0 then score_r-1,
//    else score_l+1. ev_r mirrors this. At most one of score_l/score_r is
//    nonzero once in rope mode.
//  - Win: the edge that makes a score reach WIN_PTS registers the score and
//    sets state=OVER, over=1, winright=(side==right) on that same edge.
//    Latency = 1 edge from the sampled rising level to the visible score/over.
//  - OVER: scores, over and winright hold; events are ignored; no wrap-around.
//  - new_game (either state): clears both scores, over=0, winright=0,
//    state=PLAY. It has priority over an event in the same cycle, and that
//    event is dropped.
//  - rope_mode change mid-game: takes effect on the next event; scores are
//    not modified.
//  - LEDs (combinational from the scores):
//    game_led[WIN_PTS] = 1;
//    game_led[WIN_PTS+k] = (score_l >= k);
//    game_led[WIN_PTS-k] = (score_r >= k), for k = 1..WIN_PTS.
// CONFIGURATION
//  TUG_MATCH_EN defined:
//  - Adds parameter MATCH_GAMES (default 3, odd) and outputs
//    match_l/match_r [$clog2(MATCH_GAMES+1)-1:0] and match_over (1 bit).
//  - Each entry to OVER increments the winner's match counter.
//  - match_over=1 once a counter reaches (MATCH_GAMES+1)/2. After that,
//    new_game is ignored until rst.
//  - rst clears all of these.
//  TUG_MATCH_EN undefined:
//  - None of these ports, parameters or registers exist.
//  - new_game always restarts the game.
// TESTING (WIN_PTS=3 unless noted)
//  1. Race mode: 3 left pulses -> score_l=3, game_led=7'b111_1000, over=1,
//     winright=0 on the 3rd edge.
//  2. point_r held high for 10 cycles -> score_r=1 only. ev_l and ev_r in
//     the same cycle -> scores unchanged.
//  3. Rope mode: R, R, L, L, L, L, L -> score_r 1,2,1,0, then score_l 1,2,3;
//     over=1, winright=0.
//  4. In OVER, apply 5 events -> no change. Then new_game -> scores 0,
//     over=0, game_led=7'b000_1000.
//  5. rst mid-game with score_l=2 -> all outputs at reset values the next
//     cycle. new_game coincident with ev_r -> score_r=0.
//  6. TUG_MATCH_EN, MATCH_GAMES=3: right wins 2 games -> match_r=2,
//     match_over=1; a later new_game is ignored.

Source files
------------

// File: rtl/tug_score_tracker.sv
// Tug-of-war scoreboard: edge-detected left/right point events, race or rope
// scoring, a PLAY/OVER game FSM and a symmetric thermometer LED bar.
// Optional best-of-N match tracking is enabled with the TUG_MATCH_EN macro.
module tug_score_tracker #(
    parameter int WIN_PTS = 3
`ifdef TUG_MATCH_EN
    , parameter int MATCH_GAMES = 3
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           point_l,
    input  logic                           point_r,
    input  logic                           rope_mode,
    input  logic                           new_game,
    output logic [$clog2(WIN_PTS+1)-1:0]   score_l,
    output logic [$clog2(WIN_PTS+1)-1:0]   score_r,
    output logic [2*WIN_PTS:0]             game_led,
    output logic                           over,
    output logic                           winright
`ifdef TUG_MATCH_EN
    , output logic [$clog2(MATCH_GAMES+1)-1:0] match_l,
    output logic [$clog2(MATCH_GAMES+1)-1:0]   match_r,
    output logic                           match_over
`endif
);

    localparam int CW = $clog2(WIN_PTS + 1);
    localparam logic [CW-1:0] LAST = CW'(WIN_PTS - 1);

`ifdef TUG_MATCH_EN
    localparam int MW = $clog2(MATCH_GAMES + 1);
    localparam logic [MW-1:0] NEED_LAST = MW'((MATCH_GAMES + 1) / 2 - 1);
`endif

    typedef enum logic {
        ST_PLAY,
        ST_OVER
    } state_t;

    state_t        state;
    logic          point_l_q;
    logic          point_r_q;
    logic          ev_l;
    logic          ev_r;
    logic [CW-1:0] nxt_l;
    logic [CW-1:0] nxt_r;
    logic          win_l;
    logic          win_r;
    logic          restart;

    // Rising-edge events and next-score/win candidates for a lone event
    always_comb begin
        ev_l  = point_l & ~point_l_q;
        ev_r  = point_r & ~point_r_q;
        nxt_l = score_l;
        nxt_r = score_r;
        win_l = 1'b0;
        win_r = 1'b0;
        if (ev_l && !ev_r) begin
            if (rope_mode && score_r != '0) begin
                nxt_r = score_r - 1'b1;
            end else begin
                nxt_l = score_l + 1'b1;
                win_l = (score_l == LAST);
            end
        end else if (ev_r && !ev_l) begin
            if (rope_mode && score_l != '0) begin
                nxt_l = score_l - 1'b1;
            end else begin
                nxt_r = score_r + 1'b1;
                win_r = (score_r == LAST);
            end
        end
    end

    // A finished match locks out new_game until reset
`ifdef TUG_MATCH_EN
    assign restart = new_game & ~match_over;
`else
    assign restart = new_game;
`endif

    // Game FSM with registered scores and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_PLAY;
            point_l_q <= 1'b0;
            point_r_q <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            over      <= 1'b0;
            winright  <= 1'b0;
`ifdef TUG_MATCH_EN
            match_l    <= '0;
            match_r    <= '0;
            match_over <= 1'b0;
`endif
        end else begin
            point_l_q <= point_l;
            point_r_q <= point_r;
            if (restart) begin
                state    <= ST_PLAY;
                score_l  <= '0;
                score_r  <= '0;
                over     <= 1'b0;
                winright <= 1'b0;
            end else if (state == ST_PLAY) begin
                score_l <= nxt_l;
                score_r <= nxt_r;
                if (win_l || win_r) begin
                    state    <= ST_OVER;
                    over     <= 1'b1;
                    winright <= win_r;
`ifdef TUG_MATCH_EN
                    if (win_r) begin
                        match_r <= match_r + 1'b1;
                        if (match_r == NEED_LAST) match_over <= 1'b1;
                    end else begin
                        match_l <= match_l + 1'b1;
                        if (match_l == NEED_LAST) match_over <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Thermometer bar: centre always lit, left grows upward, right downward
    always_comb begin
        game_led          = '0;
        game_led[WIN_PTS] = 1'b1;
        for (int unsigned k = 1; k <= WIN_PTS; k++) begin
            game_led[WIN_PTS+k] = (32'(score_l) >= k);
            game_led[WIN_PTS-k] = (32'(score_r) >= k);
        end
    end

endmodule
